// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-port signals around mem_port_arbiter.
// Also provides the shared MEM_READ/MEM_WRITE and DATA_BUS defaults.
`ifndef MEM_READ
`define MEM_READ 1'b0
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 1'b1
`endif
`ifndef DATA_BUS
`define DATA_BUS 32
`endif

interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = `DATA_BUS
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;

    logic                d_req;
    logic                d_rw;
    logic [ADDR_W-1:0]   d_addr;
    logic [DATA_W-1:0]   d_wdata;
    logic [DATA_W/8-1:0] d_wmask;
    logic                d_gnt;
    logic                d_rvalid;
    logic [DATA_W-1:0]   d_rdata;
    logic                d_stall;

    logic                mem_en;
    logic                mem_rw;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wmask;
    logic [DATA_W-1:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_rw, d_addr, d_wdata, d_wmask,
        input  mem_rdata,
        output if_rvalid, if_rdata, if_stall,
        output d_gnt, d_rvalid, d_rdata, d_stall,
        output mem_en, mem_rw, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_rw, d_addr, d_wdata, d_wmask,
        output mem_rdata,
        input  if_rvalid, if_rdata, if_stall,
        input  d_gnt, d_rvalid, d_rdata, d_stall,
        input  mem_en, mem_rw, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and data stage, one access in flight.
// Define MEM_PORT_ARB_FAIR_EN to bound IF starvation to FAIR_LIMIT data grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = `DATA_BUS,
    parameter int RD_LAT     = 1,
    parameter int FAIR_LIMIT = 4
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.slave  bus
);
    localparam int CW = $clog2(RD_LAT + 1);
    localparam logic [CW-1:0]       LAT = CW'(RD_LAT);
    localparam logic [ADDR_W-1:0]   A0  = '0;
    localparam logic [DATA_W-1:0]   D0  = '0;
    localparam logic [DATA_W/8-1:0] M0  = '0;

    typedef enum logic { IDLE, WAIT } state_t;
    typedef enum logic { OWN_IF, OWN_D } owner_t;

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic complete, can_issue, force_if;
    logic issue_d, issue_if, issue_rd;

    assign complete  = (state_q == WAIT) && (cnt_q == LAT);
    // Gated by reset so nothing reaches the memory while rst is held low.
    assign can_issue = rst && ((state_q == IDLE) || complete);

`ifdef MEM_PORT_ARB_FAIR_EN
    localparam int FW = $clog2(FAIR_LIMIT + 1);
    localparam logic [FW-1:0] FLIM = FW'(FAIR_LIMIT);

    logic [FW-1:0] fair_q;

    assign force_if = bus.if_req && (fair_q == FLIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fair_q <= '0;
        end else if (issue_if) begin
            fair_q <= '0;
        end else if (issue_d) begin
            if (!bus.if_req)
                fair_q <= '0;
            else if (fair_q != FLIM)
                fair_q <= fair_q + FW'(1);
        end
    end
`else
    logic unused_fair;
    assign unused_fair = |FAIR_LIMIT;
    assign force_if    = 1'b0;
`endif

    assign issue_d  = can_issue && bus.d_req && !force_if;
    assign issue_if = can_issue && bus.if_req && !issue_d;
    assign issue_rd = issue_if || (issue_d && bus.d_rw == `MEM_READ);

    always_comb begin
        bus.mem_en    = issue_d || issue_if;
        bus.mem_rw    = `MEM_READ;
        bus.mem_addr  = A0;
        bus.mem_wdata = D0;
        bus.mem_wmask = M0;
        unique case (1'b1)
            issue_d: begin
                bus.mem_rw    = bus.d_rw;
                bus.mem_addr  = bus.d_addr;
                bus.mem_wdata = bus.d_wdata;
                bus.mem_wmask = bus.d_wmask;
            end
            issue_if: bus.mem_addr = bus.if_addr;
            default: ;
        endcase
    end

    always_comb begin
        bus.d_gnt     = issue_d;
        bus.if_rvalid = complete && (owner_q == OWN_IF);
        bus.d_rvalid  = complete && (owner_q == OWN_D);
        bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : D0;
        bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : D0;
        bus.if_stall  = bus.if_req && !bus.if_rvalid;
        bus.d_stall   = bus.d_req
                      && !(issue_d && bus.d_rw == `MEM_WRITE)
                      && !bus.d_rvalid;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        if (issue_rd) begin
            state_d = WAIT;
            cnt_d   = CW'(1);
            owner_d = issue_d ? OWN_D : OWN_IF;
        end else if (state_q == WAIT && !complete) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= OWN_IF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: RD_LAT=1 and RD_LAT=2 instances,
// read data checked through per-requester expectation queues.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .FAIR_LIMIT(4))
        dut_a (.clk(clk), .rst(rst), .bus(a));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2), .FAIR_LIMIT(4))
        dut_b (.clk(clk), .rst(rst), .bus(b));

    logic [31:0] aq_if[$], aq_d[$], bq_if[$], bq_d[$];
    logic [31:0] pa1, pb1, pb2;

    function automatic logic [31:0] f(logic [31:0] ad);
        return (ad == 32'h40) ? 32'h0000_0013 : (ad ^ 32'h5A5A_0000);
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: read data appears RD_LAT cycles after the issue edge.
    always @(posedge clk) begin
        pa1 <= a.mem_addr;
        pb1 <= b.mem_addr;
        pb2 <= pb1;
    end
    assign a.mem_rdata = f(pa1);
    assign b.mem_rdata = f(pb2);

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (a.if_rvalid === 1'b1) begin
            if (aq_if.size() == 0) chk("a_if_unexpected", a.if_rvalid, 0);
            else chk("a_if_sb", a.if_rdata, aq_if.pop_front());
        end
        if (a.d_rvalid === 1'b1) begin
            if (aq_d.size() == 0) chk("a_d_unexpected", a.d_rvalid, 0);
            else chk("a_d_sb", a.d_rdata, aq_d.pop_front());
        end
        if (b.if_rvalid === 1'b1) begin
            if (bq_if.size() == 0) chk("b_if_unexpected", b.if_rvalid, 0);
            else chk("b_if_sb", b.if_rdata, bq_if.pop_front());
        end
        if (b.d_rvalid === 1'b1) begin
            if (bq_d.size() == 0) chk("b_d_unexpected", b.d_rvalid, 0);
            else chk("b_d_sb", b.d_rdata, bq_d.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        a.if_req = 0; a.if_addr = 0; a.d_req = 0; a.d_rw = `MEM_READ;
        a.d_addr = 0; a.d_wdata = 0; a.d_wmask = 0;
        b.if_req = 0; b.if_addr = 0; b.d_req = 0; b.d_rw = `MEM_READ;
        b.d_addr = 0; b.d_wdata = 0; b.d_wmask = 0;

        // Reset state, request must not leak to the memory port.
        tick();
        a.if_req = 1; a.if_addr = 32'h40;
        #1;
        chk("rst_mem_en", a.mem_en, 0);
        chk("rst_if_rvalid", a.if_rvalid, 0);
        chk("rst_d_gnt", a.d_gnt, 0);
        chk("rst_d_rvalid", a.d_rvalid, 0);
        a.if_req = 0;
        tick();
        rst = 1'b1;

        // Single fetch, RD_LAT=1.
        tick();
        a.if_req = 1; a.if_addr = 32'h40; aq_if.push_back(32'h13);
        #1;
        chk("f_mem_en", a.mem_en, 1);
        chk("f_mem_addr", a.mem_addr, 32'h40);
        chk("f_mem_rw", a.mem_rw, `MEM_READ);
        chk("f_mem_wmask", a.mem_wmask, 0);
        chk("f_if_stall0", a.if_stall, 1);
        chk("f_if_rvalid0", a.if_rvalid, 0);
        tick();
        #1;
        chk("f_if_rvalid1", a.if_rvalid, 1);
        chk("f_if_rdata1", a.if_rdata, 32'h13);
        chk("f_if_stall1", a.if_stall, 0);
        a.if_req = 0;
        #1;
        chk("f_mem_en1", a.mem_en, 0);
        chk("f_mem_addr1", a.mem_addr, 0);
        tick();
        #1;
        chk("f_if_rvalid2", a.if_rvalid, 0);

        // Store completes in its issue cycle.
        a.d_req = 1; a.d_rw = `MEM_WRITE; a.d_addr = 32'h3004;
        a.d_wdata = 32'hDEADBEEF; a.d_wmask = 4'b1111;
        #1;
        chk("st_mem_en", a.mem_en, 1);
        chk("st_d_gnt", a.d_gnt, 1);
        chk("st_mem_rw", a.mem_rw, `MEM_WRITE);
        chk("st_mem_addr", a.mem_addr, 32'h3004);
        chk("st_mem_wdata", a.mem_wdata, 32'hDEADBEEF);
        chk("st_mem_wmask", a.mem_wmask, 4'b1111);
        chk("st_d_stall", a.d_stall, 0);
        tick();
        a.d_req = 0; a.d_wmask = 0; a.d_wdata = 0;
        #1;
        chk("st_d_rvalid", a.d_rvalid, 0);
        chk("st_mem_en1", a.mem_en, 0);

        // Back-to-back loads, RD_LAT=1.
        tick();
        a.d_req = 1; a.d_rw = `MEM_READ; a.d_addr = 32'h200;
        aq_d.push_back(f(32'h200));
        #1;
        chk("bb_mem_en0", a.mem_en, 1);
        chk("bb_d_gnt0", a.d_gnt, 1);
        chk("bb_d_stall0", a.d_stall, 1);
        chk("bb_d_rvalid0", a.d_rvalid, 0);
        for (int k = 1; k <= 2; k++) begin
            tick();
            a.d_addr = 32'h200 + 32'(4 * k);
            aq_d.push_back(f(a.d_addr));
            #1;
            chk("bb_d_rvalid", a.d_rvalid, 1);
            chk("bb_d_rdata", a.d_rdata, f(32'h200 + 32'(4 * (k - 1))));
            chk("bb_mem_en", a.mem_en, 1);
            chk("bb_d_stall", a.d_stall, 0);
        end
        tick();
        a.d_req = 0;
        #1;
        chk("bb_d_rvalid3", a.d_rvalid, 1);
        chk("bb_d_rdata3", a.d_rdata, f(32'h208));
        chk("bb_mem_en3", a.mem_en, 0);
        tick();
        #1;
        chk("bb_d_rvalid4", a.d_rvalid, 0);

        // Collision, RD_LAT=2: data first, fetch in its completion cycle.
        b.if_req = 1; b.if_addr = 32'h80; bq_if.push_back(f(32'h80));
        b.d_req = 1; b.d_rw = `MEM_READ; b.d_addr = 32'h2000;
        bq_d.push_back(f(32'h2000));
        #1;
        chk("col_mem_en0", b.mem_en, 1);
        chk("col_d_gnt0", b.d_gnt, 1);
        chk("col_mem_addr0", b.mem_addr, 32'h2000);
        chk("col_if_stall0", b.if_stall, 1);
        tick();
        #1;
        chk("col_mem_en1", b.mem_en, 0);
        chk("col_if_stall1", b.if_stall, 1);
        chk("col_d_stall1", b.d_stall, 1);
        tick();
        #1;
        chk("col_d_rvalid2", b.d_rvalid, 1);
        chk("col_d_rdata2", b.d_rdata, f(32'h2000));
        b.d_req = 0;
        #1;
        chk("col_mem_en2", b.mem_en, 1);
        chk("col_mem_addr2", b.mem_addr, 32'h80);
        chk("col_d_gnt2", b.d_gnt, 0);
        chk("col_if_stall2", b.if_stall, 1);
        tick();
        #1;
        chk("col_if_stall3", b.if_stall, 1);
        chk("col_if_rvalid3", b.if_rvalid, 0);
        tick();
        #1;
        chk("col_if_rvalid4", b.if_rvalid, 1);
        chk("col_if_rdata4", b.if_rdata, f(32'h80));
        chk("col_if_stall4", b.if_stall, 0);
        b.if_req = 0;
        tick();
        #1;
        chk("col_if_rvalid5", b.if_rvalid, 0);

        // Reset one cycle before completion discards the read.
        b.if_req = 1; b.if_addr = 32'h100;
        #1;
        chk("rmr_issue", b.mem_en, 1);
        tick();
        rst = 1'b0;
        #1;
        chk("rmr_mem_en", b.mem_en, 0);
        chk("rmr_if_rvalid", b.if_rvalid, 0);
        chk("rmr_d_gnt", b.d_gnt, 0);
        b.if_req = 0;
        #1;
        chk("rmr_if_stall", b.if_stall, 0);
        chk("rmr_mem_addr", b.mem_addr, 0);
        tick();
        rst = 1'b1;
        #1;
        chk("rmr_if_rvalid2", b.if_rvalid, 0);
        chk("rmr_mem_en2", b.mem_en, 0);
        tick();
        #1;
        chk("rmr_if_rvalid3", b.if_rvalid, 0);

        // Data stores held against a waiting fetch.
        a.if_req = 1; a.if_addr = 32'h500;
        a.d_req = 1; a.d_rw = `MEM_WRITE; a.d_wmask = 4'b0011;
`ifdef MEM_PORT_ARB_FAIR_EN
        aq_if.push_back(f(32'h500));
`endif
        for (int c = 0; c < 6; c++) begin
            a.d_addr = 32'h600 + 32'(4 * c);
            #1;
`ifdef MEM_PORT_ARB_FAIR_EN
            if (c == 4) begin
                chk("fair_d_gnt_if", a.d_gnt, 0);
                chk("fair_mem_addr_if", a.mem_addr, 32'h500);
                chk("fair_mem_rw_if", a.mem_rw, `MEM_READ);
                chk("fair_d_stall_if", a.d_stall, 1);
            end else begin
                if (c == 5) begin
                    chk("fair_if_rvalid", a.if_rvalid, 1);
                    a.if_req = 0;
                    #1;
                end
                chk("fair_d_gnt", a.d_gnt, 1);
                chk("fair_mem_addr", a.mem_addr, 32'h600 + 32'(4 * c));
            end
`else
            chk("prio_d_gnt", a.d_gnt, 1);
            chk("prio_mem_addr", a.mem_addr, 32'h600 + 32'(4 * c));
            chk("prio_if_stall", a.if_stall, 1);
`endif
            tick();
        end
        a.d_req = 0; a.if_req = 0; a.d_wmask = 0;
        #1;
        chk("fair_idle_mem_en", a.mem_en, 0);
        tick();
        tick();

        chk("q_aq_if_empty", 32'(aq_if.size()), 0);
        chk("q_aq_d_empty", 32'(aq_d.size()), 0);
        chk("q_bq_if_empty", 32'(bq_if.size()), 0);
        chk("q_bq_d_empty", 32'(bq_d.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
